// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one CW-bit chunk per stage, registered inter-stage carry,
// valid/ready flow control with a single global advance enable, registered condition flags.
module pipelined_add_sub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] res_q;
  logic             res_vld_q;
  logic             res_cout_q;
  logic             res_ovf_q;
  logic             res_zero_q;
  logic             res_neg_q;

  // The whole pipeline moves as one; a stalled output freezes every stage, bubbles included.
  assign adv       = out_ready || !res_vld_q;
  assign in_ready  = adv;
  assign bx        = sub ? ~b : b;

  assign out_valid = res_vld_q;
  assign sum       = res_q;
  assign c_out     = res_cout_q;
  assign ovf       = res_ovf_q;
  assign zero      = res_zero_q;
  assign neg       = res_neg_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k consumes the lowest remaining chunk; only not-yet-added operand chunks travel on.
    localparam int SW = WIDTH - k * CW;

    logic [SW-1:0]         src_a;
    logic [SW-1:0]         src_bx;
    logic                  src_c;
    logic                  src_v;
    logic [CW:0]           chunk;
    logic [(k+1)*CW-1:0]   nxt_sum;

    if (k == 0) begin : g_src
      assign src_a   = a;
      assign src_bx  = bx;
      assign src_c   = c_in;
      assign src_v   = in_valid && in_ready;
      assign nxt_sum = chunk[CW-1:0];
    end else begin : g_src
      assign src_a   = g_stage[k-1].g_mid.a_q;
      assign src_bx  = g_stage[k-1].g_mid.bx_q;
      assign src_c   = g_stage[k-1].g_mid.cry_q;
      assign src_v   = g_stage[k-1].g_mid.vld_q;
      assign nxt_sum = {chunk[CW-1:0], g_stage[k-1].g_mid.sum_q};
    end

    assign chunk = {1'b0, src_a[CW-1:0]} + {1'b0, src_bx[CW-1:0]} + {{CW{1'b0}}, src_c};

    if (k < STAGES - 1) begin : g_mid
      logic [SW-CW-1:0]    a_q;
      logic [SW-CW-1:0]    bx_q;
      logic [(k+1)*CW-1:0] sum_q;
      logic                cry_q;
      logic                vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          bx_q  <= '0;
          sum_q <= '0;
          cry_q <= 1'b0;
          vld_q <= 1'b0;
        end else if (adv) begin
          a_q   <= src_a[SW-1:CW];
          bx_q  <= src_bx[SW-1:CW];
          sum_q <= nxt_sum;
          cry_q <= chunk[CW];
          vld_q <= src_v;
        end
      end
    end else begin : g_last
      // The top chunk still holds the operand sign bits, so overflow needs no separate copies.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q      <= '0;
          res_vld_q  <= 1'b0;
          res_cout_q <= 1'b0;
          res_ovf_q  <= 1'b0;
          res_zero_q <= 1'b0;
          res_neg_q  <= 1'b0;
        end else if (adv) begin
          res_q      <= nxt_sum;
          res_vld_q  <= src_v;
          res_cout_q <= chunk[CW];
          res_ovf_q  <= (src_a[SW-1] == src_bx[SW-1]) && (nxt_sum[WIDTH-1] != src_a[SW-1]);
          res_zero_q <= (nxt_sum == '0);
          res_neg_q  <= nxt_sum[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: a 64-bit/4-stage instance plus an 8-bit/1-stage instance,
// with a reference add model used only for the backpressure run.
module tb_pipelined_add_sub;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] a, b, sum;
  logic        sub, c_in, c_out, ovf, zero, neg;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, sum8;
  logic        sub8, c_in8, c_out8, ovf8, zero8, neg8;

  int checks = 0;
  int passes = 0;

  pipelined_add_sub #(.WIDTH(64), .STAGES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .zero(zero), .neg(neg)
  );

  pipelined_add_sub #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .sub(sub8), .c_in(c_in8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .c_out(c_out8), .ovf(ovf8), .zero(zero8), .neg(neg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Returns {c_out, ovf, zero, neg, sum} for one operation, computed at full width.
  function automatic logic [67:0] model(input logic [63:0] ma, input logic [63:0] mb,
                                        input logic msub, input logic mcin);
    logic [63:0] mbx;
    logic [64:0] t;
    logic        mo;
    mbx = msub ? ~mb : mb;
    t   = {1'b0, ma} + {1'b0, mbx} + {64'd0, mcin};
    mo  = (ma[63] == mbx[63]) && (t[63] != ma[63]);
    return {t[64], mo, (t[63:0] == 64'd0), t[63], t[63:0]};
  endfunction

  task automatic applyStimulus(input logic [63:0] va, input logic [63:0] vb, input logic vsub, input logic vcin);
    a = va; b = vb; sub = vsub; c_in = vcin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic runDirected(input string tag, input logic [63:0] va, input logic [63:0] vb,
                             input logic vsub, input logic vcin, input logic [63:0] esum,
                             input logic ec, input logic eo, input logic ez, input logic en);
    int lat;
    out_ready = 1'b1;
    applyStimulus(va, vb, vsub, vcin);
    lat = 0;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'd3);
    checkOutput({tag, "_sum"}, sum, esum);
    checkOutput({tag, "_flags"}, {60'd0, c_out, ovf, zero, neg}, {60'd0, ec, eo, ez, en});
    tick();
  endtask

  logic [63:0] opA [16];
  logic [63:0] opB [16];
  logic        opS [16];
  logic        opC [16];
  logic [67:0] expQ [$];
  logic [67:0] expV;
  logic [63:0] heldSum;
  logic [4:0]  heldFlags;
  int          issued, consumed, cyc, stale;
  logic        stalled, acc, pop;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0; c_in = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; sub8 = 1'b0; c_in8 = 1'b0;
    #12;
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_sum", sum, 64'd0);
    checkOutput("reset_flags", {60'd0, c_out, ovf, zero, neg}, 64'd0);
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    runDirected("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    runDirected("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    runDirected("borrow", 64'd0, 64'd1, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    runDirected("sub_equal", 64'd5, 64'd5, 1'b1, 1'b1,
                64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    runDirected("adc_chunk", 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0000, 1'b0, 1'b1,
                64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Backpressure run with random operands and pseudo-random out_ready.
    for (int i = 0; i < 16; i++) begin
      opA[i] = {$urandom, $urandom};
      opB[i] = {$urandom, $urandom};
      opS[i] = 1'($urandom_range(0, 1));
      opC[i] = 1'($urandom_range(0, 1));
    end
    issued = 0; consumed = 0; cyc = 0; stalled = 1'b0;
    while (consumed < 16 && cyc < 400) begin
      if (issued < 16) begin
        in_valid = 1'b1; a = opA[issued]; b = opB[issued]; sub = opS[issued]; c_in = opC[issued];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        checkOutput("stall_hold_sum", sum, heldSum);
        checkOutput("stall_hold_flags", {59'd0, out_valid, c_out, ovf, zero, neg}, {59'd0, heldFlags});
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (out_valid && !out_ready) begin
        checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
        stalled   = 1'b1;
        heldSum   = sum;
        heldFlags = {out_valid, c_out, ovf, zero, neg};
      end else begin
        stalled = 1'b0;
      end
      if (pop) begin
        if (expQ.size() == 0) begin
          checkOutput("bp_extra_result", 64'd1, 64'd0);
        end else begin
          expV = expQ.pop_front();
          checkOutput("bp_sum", sum, expV[63:0]);
          checkOutput("bp_flags", {60'd0, c_out, ovf, zero, neg}, {60'd0, expV[67:64]});
        end
        consumed++;
      end
      if (acc) begin
        expQ.push_back(model(opA[issued], opB[issued], opS[issued], opC[issued]));
        issued++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp_consumed", 64'(consumed), 64'd16);
    checkOutput("bp_queue_empty", 64'(expQ.size()), 64'd0);
    tick();
    checkOutput("bp_no_extra", {63'd0, out_valid}, 64'd0);

    // Mid-stream reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 64'(i + 1); b = 64'd1; sub = 1'b0; c_in = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    tick();
    checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("async_reset_sum", sum, 64'd0);
    #2;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) stale++;
    end
    checkOutput("no_stale_result", 64'(stale), 64'd0);
    runDirected("post_reset", 64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Degenerate single-stage 8-bit instance.
    checkOutput("deg_idle_valid", {63'd0, out_valid8}, 64'd0);
    a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0; c_in8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    checkOutput("deg_valid", {63'd0, out_valid8}, 64'd1);
    checkOutput("deg_sum", {56'd0, sum8}, 64'd0);
    checkOutput("deg_flags", {60'd0, c_out8, ovf8, zero8, neg8}, {60'd0, 4'b1110});
    tick();
    checkOutput("deg_drained", {63'd0, out_valid8}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined integer adder/subtractor with valid/ready flow control and registered condition flags. Operands of WIDTH bits are split into STAGES equal chunks. One chunk is added per pipeline stage, and the carry is registered between stages. This sustains one operation per cycle at a clock rate set by a WIDTH/STAGES-bit carry chain. It is the ALU's arithmetic unit for ADD/ADC/SUB/SBB/CMP and replaces the combinational 64-bit ripple adder.

## Interface
- WIDTH, 64: operand/result width in bits; must be divisible by STAGES.
- STAGES, 4: number of pipeline stages and chunks; chunk width CW = WIDTH/STAGES; legal range 1..WIDTH.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand set present.
- in_ready  out  1  pipeline can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: A+B+c_in; 1: A+~B+c_in (A−B when c_in=1).
- c_in  in  1  carry/not-borrow in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- c_out  out  1  carry out of bit WIDTH−1; for sub=1, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH−1].

## Operation
- Effective operand: bx = sub ? ~b : b, formed at input.
- Stage k (1..STAGES) holds the following:
  - sum chunks 0..k−1 computed so far;
  - a and bx chunks k..STAGES−1 not yet added;
  - registered carry out of chunk k−1;
  - sign bits a[MSB] and bx[MSB];
  - a valid bit.
- Stage 1 adds chunk 0 with c_in. Stage k adds chunk k−1 with the carry from stage k−1.
- Final stage registers the following:
  - full sum;
  - c_out = carry out of the top chunk;
  - ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]);
  - zero;
  - neg.
- All outputs are driven directly from final-stage registers. There is no combinational path from a/b to the outputs.
- Global advance enable: adv = out_ready || !out_valid. Every stage captures from its predecessor when adv=1 and holds when adv=0.
- in_ready = adv (combinational from out_ready and out_valid only). An operation is accepted when in_valid && in_ready at a rising edge.
- Stage 1 valid captures (in_valid && in_ready) when adv=1. Bubbles are not compressed while stalled.
- Results emerge in acceptance order. No operation is dropped or duplicated.
- Reset (rst_n low, any time, including mid-stream):
  - all valid bits, carries, sum, and flags clear to 0 immediately;
  - out_valid=0, sum=0, c_out=0, ovf=0, zero=0, neg=0;
  - in_ready=1 once rst_n is high (out_valid is 0);
  - in-flight operations are discarded.
- STAGES=1 degenerates to a single registered full-width add with the same handshake.

## Timing
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+STAGES−1. For STAGES=1 it appears right after the accept edge.
- Throughput: one operation per cycle while out_ready=1.
- Stall:
  - while out_valid && !out_ready, all stages hold and in_ready=0;
  - sum and flags remain stable until the accepting edge.
- Simultaneous accept at input and output on the same edge is legal. This is full-throughput operation.
- Critical path: one CW-bit carry chain plus the stage mux.
- Flags ovf, zero, and neg are valid only when out_valid=1.

## Test plan
- **Signed overflow.**
  - Stimulus (WIDTH=64, STAGES=4): a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0, c_in=0, out_ready=1.
  - Required response: out_valid 4 cycles after accept; sum=0x8000_0000_0000_0000, ovf=1, c_out=0, neg=1, zero=0.
- **Carry through all stages.**
  - Stimulus: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, c_in=0.
  - Required response: sum=0, c_out=1, ovf=0, zero=1, neg=0.
- **Borrow.**
  - Stimulus: a=0, b=1, sub=1, c_in=1.
  - Required response: sum=0xFFFF_FFFF_FFFF_FFFF, c_out=0, ovf=0, neg=1.
  - Follow-up: a=5, b=5, sub=1, c_in=1 gives sum=0, zero=1, c_out=1.
- **Back-to-back with backpressure.**
  - Stimulus: 16 consecutive random operations; out_ready toggling pseudo-randomly.
  - Required response: results match the reference model, in order, with none lost or duplicated.
  - While out_valid && !out_ready: in_ready=0, and sum/flags do not change.
- **Reset mid-stream.**
  - Stimulus: 3 operations in flight; assert rst_n=0 asynchronously between edges.
  - Required response: out_valid=0 and sum=0 without waiting for a clock edge.
  - After release: no stale result appears; a new operation 2+3 yields 5 after 4 cycles.
- **Degenerate parameters.**
  - Stimulus: STAGES=1, WIDTH=8, a=0x80, b=0x80, sub=0, c_in=0.
  - Required response: sum=0x00, c_out=1, ovf=1, zero=1, result one cycle after accept.
